key_ctrl: RTL
=============

KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CNT, default 1_000_000, giving the debounce window in clk cycles (10 ms at 100 MHz); legal range is 2 to 2^32-1.
REQ-002 The block SHALL have parameter LONG_CNT, default 100_000_000, giving the long-press threshold in clk cycles (1 s); it SHALL satisfy LONG_CNT > DEB_CNT.
REQ-003 The block SHALL have port clk, input, 1 bit: 100 MHz clock; the block SHALL use only this one clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port key_run, input, 1 bit: raw run/stop push-button, active-high, asynchronous to clk, bouncy.
REQ-006 The block SHALL have port key_freq, input, 1 bit: raw frequency push-button, same electrical properties as key_run.
REQ-007 The block SHALL have port key_dir, input, 1 bit: raw direction push-button, same electrical properties as key_run.
REQ-008 The block SHALL have port run_toggle, output, 1 bit: one-cycle pulse, drives the marquee button input.
REQ-009 The block SHALL have port freq_set, output, 2 bits: frequency select for the marquee.
REQ-010 The block SHALL have port dir_set, output, 1 bit: direction for the marquee; 1 = left, 0 = right.
REQ-011 The block SHALL have port key_level, output, 3 bits: debounced key levels {dir, freq, run}.

Function
REQ-012 Each raw key SHALL pass through a two-flop synchronizer; the second flop output (key_s) is the only version of the key used by any logic.
REQ-013 Each key SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a 32-bit debounce counter.
REQ-014 In IDLE with key_s=1, the FSM SHALL move to PRESS_WAIT and load cnt=1; with key_s=0 it SHALL stay in IDLE.
REQ-015 In PRESS_WAIT with key_s=0, the FSM SHALL return to IDLE with cnt=0 and generate no event.
REQ-016 In PRESS_WAIT with key_s=1, the FSM SHALL increment cnt; on the cycle cnt reaches DEB_CNT it SHALL enter PRESSED and assert an internal press event for exactly that one cycle.
REQ-017 In PRESSED with key_s=0, the FSM SHALL move to RELEASE_WAIT and load cnt=1.
REQ-018 In RELEASE_WAIT with key_s=1, the FSM SHALL return to PRESSED without generating an event.
REQ-019 In RELEASE_WAIT with key_s=0 and cnt reaching DEB_CNT, the FSM SHALL enter IDLE and assert the release event for one cycle.
REQ-020 key_level[i] SHALL be 1 while FSM i is in PRESSED or RELEASE_WAIT, and 0 otherwise.
REQ-021 A run press event SHALL drive run_toggle=1 on the next clk edge, for exactly one cycle; there SHALL be one pulse per debounced press.
REQ-022 A dir press event SHALL invert dir_set on the next clk edge.
REQ-023 For the freq key, a 32-bit hold counter SHALL clear on press event, increment in PRESSED, and freeze in RELEASE_WAIT.
REQ-024 When the freq hold counter reaches LONG_CNT, freq_set SHALL go to 2'b00 on the next edge and long_flag SHALL be set; the hold counter SHALL saturate at LONG_CNT.
REQ-025 On a freq release event with long_flag=0, freq_set SHALL increment on the next edge, wrapping 2'b11 -> 2'b00.
REQ-026 On a freq release event with long_flag=1, freq_set SHALL be unchanged and long_flag SHALL clear.
REQ-027 Any input pulse or bounce train shorter than DEB_CNT consecutive key_s-high cycles SHALL produce no event.
REQ-028 The three keys SHALL be fully independent; simultaneous events on different keys SHALL all take effect in the same cycle.
REQ-029 Response latency SHALL be: raw edge to key_s = 2 cycles; key_s high to press event = DEB_CNT cycles; event to output change = 1 cycle.

Reset
REQ-030 While rst=1 at a clk edge, all FSMs SHALL go to IDLE, all counters SHALL be 0, long_flag SHALL be 0 and the synchronizer flops SHALL be 0.
REQ-031 Output reset values SHALL be: run_toggle=0, freq_set=2'b00, dir_set=1, key_level=3'b000.
REQ-032 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no event.
REQ-033 A key still held when rst deasserts SHALL be debounced afresh and SHALL produce one press event DEB_CNT cycles after key_s is first sampled high.

Verification (DEB_CNT=4, LONG_CNT=20)
REQ-034 Hold key_run high for 10 cycles, then release -> exactly one run_toggle pulse, DEB_CNT+3 cycles after the raw rise; key_level[0] returns to 0 after release debounce.
REQ-035 Drive key_dir with a bounce train (high 2, low 1, high 2, low 1), then hold high 8 cycles -> no event during the bounces; dir_set 1 -> 0 exactly once.
REQ-036 Apply four short freq presses (8 cycles high, 8 cycles low each) -> freq_set sequence 01, 10, 11, 00, each change one cycle after its release event.
REQ-037 Apply two short freq presses (freq_set=10), then hold key_freq 40 cycles -> freq_set=00 once the hold counter reaches 20; the release leaves freq_set at 00.
REQ-038 Press key_run and key_dir raw-simultaneously -> run_toggle pulse and dir_set flip occur on the same cycle.
REQ-039 Assert rst during PRESS_WAIT of key_run -> no pulse; outputs return to the reset values; the key still held after rst deasserts yields one pulse DEB_CNT+1 cycles later.

Source files
------------

// File: rtl/key_ctrl.sv
// Three-key debouncer driving marquee controls: run pulse, direction toggle,
// frequency select with short-press increment and long-press reset to 2'b00.
//   state        | meaning
//   IDLE         | key released and stable
//   PRESS_WAIT   | key_s high, counting toward a debounced press
//   PRESSED      | debounced press, key still high
//   RELEASE_WAIT | key_s low, counting toward a debounced release
module key_ctrl #(
  parameter logic [31:0] DEB_CNT  = 32'd1_000_000,
  parameter logic [31:0] LONG_CNT = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_run,
  input  logic       key_freq,
  input  logic       key_dir,
  output logic       run_toggle,
  output logic [1:0] freq_set,
  output logic       dir_set,
  output logic [2:0] key_level
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [2:0]  key_raw;
  logic [2:0]  sync1_q, key_s_q;
  state_t      state_q [3];
  state_t      state_d [3];
  logic [31:0] cnt_q [3];
  logic [31:0] cnt_d [3];
  logic [2:0]  press_q, press_d, rel_q, rel_d;
  logic [31:0] hold_q, hold_d;
  logic        long_q, long_d;
  logic        run_toggle_q, run_toggle_d;
  logic [1:0]  freq_q, freq_d;
  logic        dir_q, dir_d;

  assign key_raw = {key_dir, key_freq, key_run};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      key_s_q      <= '0;
      press_q      <= '0;
      rel_q        <= '0;
      hold_q       <= '0;
      long_q       <= 1'b0;
      run_toggle_q <= 1'b0;
      freq_q       <= 2'b00;
      dir_q        <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q      <= key_raw;
      key_s_q      <= sync1_q;
      press_q      <= press_d;
      rel_q        <= rel_d;
      hold_q       <= hold_d;
      long_q       <= long_d;
      run_toggle_q <= run_toggle_d;
      freq_q       <= freq_d;
      dir_q        <= dir_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // The IDLE exit loads cnt=1 so cnt equals the number of consecutive
  // matching key_s samples; the event fires on the DEB_CNT-th sample.
  always_comb begin
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (key_s_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = 32'd1;
          end else begin
            cnt_d[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_s_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + 32'd1 == DEB_CNT) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        PRESSED: begin
          if (!key_s_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = 32'd1;
          end
        end
        RELEASE_WAIT: begin
          if (key_s_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + 32'd1 == DEB_CNT) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    run_toggle_d = press_q[0];
    dir_d        = dir_q ^ press_q[2];
    hold_d       = hold_q;
    long_d       = long_q;
    freq_d       = freq_q;
    if (press_q[1]) begin
      hold_d = '0;
    end else if (state_q[1] == PRESSED) begin
      if (hold_q < LONG_CNT) begin
        hold_d = hold_q + 32'd1;
      end else if (!long_q) begin
        freq_d = 2'b00;
        long_d = 1'b1;
      end
    end
    // A release after a long press only re-arms; short releases step freq.
    if (rel_q[1]) begin
      if (long_q) long_d = 1'b0;
      else        freq_d = freq_q + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      key_level[i] = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
  end

  assign run_toggle = run_toggle_q;
  assign freq_set   = freq_q;
  assign dir_set    = dir_q;

endmodule
